// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every signal of the shared-RAM sequencer apart from clock and reset.
//   Pipeline side : if_req/if_addr (IF stage), mem_req/mem_we/mem_addr/mem_wdata
//                   (MEM stage), if_rdata/mem_rdata (returned words),
//                   stall/step_done/bus_err (pipeline control).
//   RAM side      : ram_en/ram_we/ram_addr/ram_wdata (access request),
//                   ram_rdata/ram_ack (access completion).
// Modport master is the arbiter's view; modport slave is the view of the
// pipeline and the RAM that surround it.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        step_done;
    logic        bus_err;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata, ram_ack,
        output if_rdata, mem_rdata, stall, step_done, bus_err,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata, ram_ack,
        input  if_rdata, mem_rdata, stall, step_done, bus_err,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port RAM between instruction fetch and the MEM stage.
// Each pipeline step is one transaction: data access first (if any), then
// fetch (if any). stall holds the pipeline until the DONE cycle, where
// step_done pulses and the pipeline registers load.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - mem_arbiter_if.master (pipeline requests/results and RAM bus)
// Parameter:
//   TIMEOUT - cycles allowed per access before it is aborted (2..255)
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last wait-count value; reaching it without an ack aborts the access.
    localparam logic [7:0] WAIT_LAST_C = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_cnt_r;
    logic        pend_if_r;
    logic        err_flag_r;
    logic        ack_s;
    logic        abort_s;
    logic        leave_s;
    logic        stall_s;

    logic [31:0] if_rdata_r;
    logic [31:0] mem_rdata_r;
    logic        step_done_r;
    logic        bus_err_r;
    logic        ram_en_r;
    logic        ram_we_r;
    logic [31:0] ram_addr_r;
    logic [31:0] ram_wdata_r;

    // Access completion: ack or timeout, only meaningful while an access is open.
    always_comb begin
        ack_s   = 1'b0;
        abort_s = 1'b0;
        if (state_r == DATA || state_r == INST) begin
            ack_s   = bus.ram_ack;
            abort_s = !bus.ram_ack && (wait_cnt_r == WAIT_LAST_C);
        end else begin
            ack_s   = 1'b0;
            abort_s = 1'b0;
        end
        leave_s = ack_s | abort_s;
    end

    // Next-state decision and the combinational stall.
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = bus.if_req | bus.mem_req;
                if (bus.mem_req) begin
                    state_next_s = DATA;
                end else if (bus.if_req) begin
                    state_next_s = INST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DATA: begin
                stall_s = 1'b1;
                if (leave_s) begin
                    state_next_s = pend_if_r ? INST : DONE;
                end else begin
                    state_next_s = DATA;
                end
            end
            INST: begin
                stall_s = 1'b1;
                if (leave_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = INST;
                end
            end
            DONE: begin
                stall_s      = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                stall_s      = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait counter restarts on every state change, so DATA->INST starts fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= 8'd0;
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == DATA || state_r == INST) && !bus.ram_ack) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    // Error flag survives the whole step and is dropped as DONE hands back to IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_flag_r <= 1'b0;
        end else if (state_r == DONE) begin
            err_flag_r <= 1'b0;
        end else if (abort_s) begin
            err_flag_r <= 1'b1;
        end
    end

    // Registered RAM bus, read-data capture and step status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_if_r   <= 1'b0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= 32'h0;
            ram_wdata_r <= 32'h0;
            if_rdata_r  <= 32'h0;
            mem_rdata_r <= 32'h0;
            step_done_r <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            // Both flags line up with the DONE cycle; an abort in the final
            // access must still show up, hence the abort_s term.
            step_done_r <= (state_next_s == DONE);
            bus_err_r   <= (state_next_s == DONE) && (err_flag_r || abort_s);
            case (state_r)
                IDLE: begin
                    if (bus.mem_req) begin
                        ram_en_r    <= 1'b1;
                        ram_we_r    <= bus.mem_we;
                        ram_addr_r  <= bus.mem_addr;
                        ram_wdata_r <= bus.mem_wdata;
                        pend_if_r   <= bus.if_req;
                    end else if (bus.if_req) begin
                        ram_en_r    <= 1'b1;
                        ram_we_r    <= 1'b0;
                        ram_addr_r  <= bus.if_addr;
                    end
                end
                DATA: begin
                    if (leave_s) begin
                        // A store has no destination register, even on abort.
                        if (!ram_we_r) begin
                            mem_rdata_r <= ack_s ? bus.ram_rdata : 32'h0;
                        end
                        if (pend_if_r) begin
                            ram_en_r   <= 1'b1;
                            ram_we_r   <= 1'b0;
                            ram_addr_r <= bus.if_addr;
                        end else begin
                            ram_en_r <= 1'b0;
                            ram_we_r <= 1'b0;
                        end
                    end
                end
                INST: begin
                    if (leave_s) begin
                        if_rdata_r <= ack_s ? bus.ram_rdata : 32'h0;
                        ram_en_r   <= 1'b0;
                        ram_we_r   <= 1'b0;
                    end
                end
                DONE: begin
                    ram_en_r <= 1'b0;
                    ram_we_r <= 1'b0;
                end
                default: begin
                    ram_en_r <= 1'b0;
                    ram_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall     = stall_s;
    assign bus.step_done = step_done_r;
    assign bus.bus_err   = bus_err_r;
    assign bus.ram_en    = ram_en_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_wdata = ram_wdata_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.mem_rdata = mem_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter (TIMEOUT = 4). Inputs change 1 time unit
// after each rising edge; outputs are sampled 3 time units after the edge.
module tb_mem_arbiter;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic no_req();
        bus.if_req    = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.ram_ack   = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.if_addr   = 32'h0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.ram_rdata = 32'h0;
        no_req();
        #2 reset = 1'b0;
        #1;
        chk("rst_ram_en", {31'h0, bus.ram_en}, 32'h0);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_step_done", {31'h0, bus.step_done}, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // Fetch only, zero wait.
        bus.if_req = 1'b1; bus.if_addr = 32'h40; settle();
        chk("f_stall_c1", {31'h0, bus.stall}, 32'h1);
        chk("f_ram_en_c1", {31'h0, bus.ram_en}, 32'h0);
        cyc();
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h20080005; settle();
        chk("f_stall_c2", {31'h0, bus.stall}, 32'h1);
        chk("f_ram_en_c2", {31'h0, bus.ram_en}, 32'h1);
        chk("f_ram_addr", bus.ram_addr, 32'h40);
        chk("f_ram_we", {31'h0, bus.ram_we}, 32'h0);
        cyc();
        no_req(); settle();
        chk("f_stall_c3", {31'h0, bus.stall}, 32'h0);
        chk("f_step_done", {31'h0, bus.step_done}, 32'h1);
        chk("f_if_rdata", bus.if_rdata, 32'h20080005);
        chk("f_ram_en_c3", {31'h0, bus.ram_en}, 32'h0);
        chk("f_bus_err", {31'h0, bus.bus_err}, 32'h0);
        cyc(); settle();
        chk("f_step_done_end", {31'h0, bus.step_done}, 32'h0);

        // LW + fetch, zero wait.
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h100;
        bus.if_req = 1'b1; bus.if_addr = 32'h44; settle();
        chk("lf_stall_c1", {31'h0, bus.stall}, 32'h1);
        cyc();
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'hDEADBEEF; settle();
        chk("lf_addr_data", bus.ram_addr, 32'h100);
        chk("lf_stall_c2", {31'h0, bus.stall}, 32'h1);
        cyc();
        bus.ram_rdata = 32'h8C090100; settle();
        chk("lf_addr_inst", bus.ram_addr, 32'h44);
        chk("lf_en_inst", {31'h0, bus.ram_en}, 32'h1);
        chk("lf_mem_rdata_early", bus.mem_rdata, 32'hDEADBEEF);
        chk("lf_stall_c3", {31'h0, bus.stall}, 32'h1);
        cyc();
        no_req(); settle();
        chk("lf_stall_c4", {31'h0, bus.stall}, 32'h0);
        chk("lf_step_done", {31'h0, bus.step_done}, 32'h1);
        chk("lf_mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
        chk("lf_if_rdata", bus.if_rdata, 32'h8C090100);
        cyc();

        // SW with two wait states.
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h200;
        bus.mem_wdata = 32'h12345678; settle();
        chk("sw_stall_c1", {31'h0, bus.stall}, 32'h1);
        cyc(); settle();
        chk("sw_we_c2", {31'h0, bus.ram_we}, 32'h1);
        chk("sw_wdata", bus.ram_wdata, 32'h12345678);
        chk("sw_addr", bus.ram_addr, 32'h200);
        cyc(); settle();
        chk("sw_we_c3", {31'h0, bus.ram_we}, 32'h1);
        chk("sw_stall_c3", {31'h0, bus.stall}, 32'h1);
        cyc();
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'hCAFEF00D; settle();
        chk("sw_we_c4", {31'h0, bus.ram_we}, 32'h1);
        chk("sw_stall_c4", {31'h0, bus.stall}, 32'h1);
        cyc();
        no_req(); settle();
        chk("sw_stall_c5", {31'h0, bus.stall}, 32'h0);
        chk("sw_step_done", {31'h0, bus.step_done}, 32'h1);
        chk("sw_we_done", {31'h0, bus.ram_we}, 32'h0);
        chk("sw_mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
        cyc();

        // Idle noise: ack toggles with no request.
        bus.ram_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            bus.ram_ack = ~bus.ram_ack; settle();
            chk("noise_ram_en", {31'h0, bus.ram_en}, 32'h0);
            chk("noise_step_done", {31'h0, bus.step_done}, 32'h0);
            cyc();
        end
        bus.ram_ack = 1'b0; settle();
        chk("noise_if_rdata", bus.if_rdata, 32'h8C090100);
        chk("noise_mem_rdata", bus.mem_rdata, 32'hDEADBEEF);

        // Fetch timeout with TIMEOUT = 4.
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        cyc();
        cyc(); cyc(); cyc(); settle();
        chk("to_en_c4", {31'h0, bus.ram_en}, 32'h1);
        chk("to_stall_c4", {31'h0, bus.stall}, 32'h1);
        chk("to_bus_err_c4", {31'h0, bus.bus_err}, 32'h0);
        cyc();
        no_req(); settle();
        chk("to_bus_err", {31'h0, bus.bus_err}, 32'h1);
        chk("to_step_done", {31'h0, bus.step_done}, 32'h1);
        chk("to_if_rdata", bus.if_rdata, 32'h0);
        chk("to_ram_en", {31'h0, bus.ram_en}, 32'h0);
        cyc(); settle();
        chk("to_bus_err_after", {31'h0, bus.bus_err}, 32'h0);

        // Reset in the middle of a data wait.
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h300;
        cyc(); settle();
        chk("rm_en_before", {31'h0, bus.ram_en}, 32'h1);
        cyc();
        #1;
        no_req();
        reset = 1'b0;
        #1;
        chk("rm_ram_en", {31'h0, bus.ram_en}, 32'h0);
        chk("rm_stall", {31'h0, bus.stall}, 32'h0);
        chk("rm_mem_rdata", bus.mem_rdata, 32'h0);
        chk("rm_if_rdata", bus.if_rdata, 32'h0);
        cyc(); cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            chk("post_rst_ram_en", {31'h0, bus.ram_en}, 32'h0);
            chk("post_rst_step_done", {31'h0, bus.step_done}, 32'h0);
            chk("post_rst_stall", {31'h0, bus.stall}, 32'h0);
        end
        chk("post_rst_ram_addr", bus.ram_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
